// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the two-port data-RAM arbiter:
//   - arb_state_t : FSM state encoding (IDLE=0, ACCESS=1, RESP=2)
//   - CORE / HOST : port identifiers used for gnt_id and last_gnt
// Optional feature macro used by the files importing this package:
//   DMEM_ARB_RR_EN : round-robin on contention (default: core priority)
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic CORE = 1'b0;
    localparam logic HOST = 1'b1;

endpackage : dmem_arb_pkg

// File: rtl/arb_pick2.sv
// -----------------------------------------------------------------------------
// arb_pick2
// Combinational two-requester grant decision.
// Ports:
//   req0, req1 : request from CORE (0) and HOST (1)
//   last_gnt   : port that won the previous grant (used only for round-robin)
//   win_id     : winning port id, meaningful when win_valid is high
//   win_valid  : at least one request is present
// Feature macro: DMEM_ARB_RR_EN selects round-robin on contention; without it
// the core always wins and last_gnt is ignored.
// -----------------------------------------------------------------------------
module arb_pick2
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic win_id,
    output logic win_valid
);

`ifndef DMEM_ARB_RR_EN
    // Fixed priority never looks at history.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

    always_comb begin
        win_valid = req0 | req1;
        win_id    = CORE;
        if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
            // Contention goes to whichever port did not win last time.
            win_id = ~last_gnt;
`else
            win_id = CORE;
`endif
        end else if (req1) begin
            win_id = HOST;
        end
    end

endmodule : arb_pick2

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data RAM between a core port (0) and a host/loader
// port (1). Each access takes exactly three cycles: IDLE (request sampled),
// ACCESS (RAM driven), RESP (ack + read data from the RAM).
//
// Handshake: a requester raises req with we/addr/wdata and holds all of them
// stable until it sees its ack pulse (one cycle, in RESP). The fields are
// latched at the IDLE edge, so later changes do not disturb the access in
// flight. req still high in the cycle after ack is taken as a new request.
// The losing port's request simply stays pending for the next IDLE.
//
// Parameters: ADDR_W (address width), DATA_W (word width)
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata, c_ack/c_rdata : core port
//   h_req/h_we/h_addr/h_wdata, h_ack/h_rdata : host port
//   ram_addr/ram_we/ram_din : RAM drive; ram_dout : RAM data, one cycle latency
//   busy                    : FSM not in IDLE
//   gnt_id                  : port currently owning the RAM
//   dbg_state               : current FSM state, for observation
// Feature macro: DMEM_ARB_RR_EN enables round-robin contention via last_gnt;
// when undefined the core always wins and no last_gnt register exists.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    // core port
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    // host port
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_ack,
    output logic [DATA_W-1:0] h_rdata,
    // RAM side
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    // status
    output logic              busy,
    output logic              gnt_id,
    output arb_state_t        dbg_state
);

    arb_state_t        state;
    arb_state_t        state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              gnt_q;
    logic              last_gnt;
    logic              win_id;
    logic              win_valid;
    logic              grant;

    // A grant happens only from IDLE.
    assign grant = (state == IDLE) && win_valid;

    arb_pick2 u_pick (
        .req0      (c_req),
        .req1      (h_req),
        .last_gnt  (last_gnt),
        .win_id    (win_id),
        .win_valid (win_valid)
    );

`ifdef DMEM_ARB_RR_EN
    logic last_gnt_q;

    // Reset to HOST so the core wins the first contended grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q <= HOST;
        end else if (grant) begin
            last_gnt_q <= win_id;
        end
    end

    assign last_gnt = last_gnt_q;
`else
    assign last_gnt = HOST;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Request capture: the winner's fields are frozen for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            gnt_q   <= CORE;
        end else if (grant) begin
            gnt_q <= win_id;
            if (win_id == HOST) begin
                addr_q  <= h_addr;
                wdata_q <= h_wdata;
                we_q    <= h_we;
            end else begin
                addr_q  <= c_addr;
                wdata_q <= c_wdata;
                we_q    <= c_we;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win_valid) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs. Write-enable and acks are masked by reset so that an access
    // aborted by reset neither commits its write nor signals completion.
    always_comb begin
        ram_addr = addr_q;
        ram_din  = wdata_q;
        ram_we   = (state == ACCESS) && we_q && !reset;
        c_ack    = (state == RESP) && (gnt_q == CORE) && !reset;
        h_ack    = (state == RESP) && (gnt_q == HOST) && !reset;
        c_rdata  = '0;
        h_rdata  = '0;
        if (state == RESP) begin
            if (gnt_q == CORE) begin
                c_rdata = ram_dout;
            end else begin
                h_rdata = ram_dout;
            end
        end
        busy      = (state != IDLE);
        gnt_id    = gnt_q;
        dbg_state = state;
    end

endmodule : dmem_arbiter

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10: data-RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8: data-RAM word width.
REQ-003 The block SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 The block SHALL have ports c_req/c_we  input  1 each: core request and write-enable (port 0).
REQ-006 The block SHALL have ports c_addr  input  ADDR_W and c_wdata  input  DATA_W: core address and write data.
REQ-007 The block SHALL have ports c_ack  output  1 and c_rdata  output  DATA_W: core completion pulse and read data.
REQ-008 The block SHALL have ports h_req, h_we, h_addr, h_wdata, h_ack and h_rdata: host/loader port 1, with the same directions, widths and meanings as port 0.
REQ-009 The block SHALL have ports ram_addr  output  ADDR_W, ram_we  output  1 and ram_din  output  DATA_W: drive to the single-port data RAM.
REQ-010 The block SHALL have port ram_dout  input  DATA_W: RAM read data, valid one clock after the address is presented.
REQ-011 The block SHALL have ports busy  output  1 (FSM not in IDLE) and gnt_id  output  1 (port currently owning the RAM).

Function
REQ-012 The block SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE; no other transitions.
REQ-013 In IDLE with any req high, the block SHALL select a winner, latch its addr/we/wdata into registers and gnt_id, and enter ACCESS.
REQ-014 In IDLE with no req, the block SHALL remain in IDLE with ram_we=0.
REQ-015 In ACCESS, ram_addr/ram_din SHALL equal the latched values and ram_we SHALL equal the latched we, for exactly one cycle.
REQ-016 In RESP, the winner's ack SHALL pulse high for one cycle and its rdata SHALL equal ram_dout; for writes, rdata is don't-care.
REQ-017 The loser's ack SHALL stay 0; the loser's request remains pending and is arbitrated on the next IDLE.
REQ-018 Latency SHALL be a fixed 3 cycles from the req-sampled edge to the ack cycle; peak throughput is one access per 3 cycles.
REQ-019 A requester SHALL hold req and its fields stable until ack; req still high in the cycle after ack counts as a new request.
REQ-020 Changes to req fields after the IDLE edge SHALL NOT affect the access in flight.
REQ-021 The addr range is 0 to 2^ADDR_W-1 with no wrap logic; the address is passed through unmodified.
REQ-022 ram_we SHALL never be high outside ACCESS.

Reset
REQ-023 On a reset edge the block SHALL enter IDLE, whatever the current state.
REQ-024 From the cycle after reset is sampled, until the next grant, the following outputs SHALL be 0: c_ack, h_ack, ram_we, ram_addr, ram_din, c_rdata, h_rdata, busy and gnt_id.
REQ-025 Reset during ACCESS or RESP SHALL abort the access: no ack is issued and the requester must re-request.
REQ-026 Reset SHALL set last_gnt to 1, so the core wins the first contended grant.

Configuration
REQ-027 With DMEM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the port not equal to last_gnt, and last_gnt SHALL update on every grant.
REQ-028 With DMEM_ARB_RR_EN undefined, port 0 (core) SHALL always win contention and the last_gnt register SHALL be absent.

Structure
REQ-029 State encoding (IDLE=0, ACCESS=1, RESP=2) and the port-id constants (CORE=0, HOST=1) SHALL live in the shared package dmem_arb_pkg.
REQ-030 The grant decision SHALL be a sub-module arb_pick2 (inputs: two reqs and last_gnt; outputs: winner id and valid); the FSM and registers stay in dmem_arbiter.

Verification
REQ-031 Core write only: c_req=1, c_we=1, c_addr=0x005, c_wdata=0xA5 -> ram_we=1 with addr 0x005 and din 0xA5 two edges later, then c_ack one cycle later.
REQ-032 Host read of 0x005 after that write -> h_ack on the third cycle with h_rdata=0xA5, and c_ack stays 0.
REQ-033 Both reqs held high for 12 cycles (RR_EN defined) -> grants CORE, HOST, CORE, HOST with acks 3 cycles apart; with RR_EN undefined -> all four grants go to CORE.
REQ-034 Reset asserted in ACCESS during a core write to 0x3FF -> no c_ack, busy=0 next cycle, and a following read of 0x3FF returns the prior value, not the aborted data.
REQ-035 Idle bench with no reqs for 20 cycles -> ram_we, busy and both acks stay 0 throughout.
